// File: rtl/dff_bank_arbiter_pkg.sv
// Shared definitions for the register-bank arbiter: FSM encoding and
// index-width helper used to size the round-robin pointer and counters.
package dff_bank_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_OWNED   = 2'd1,
        S_RELEASE = 2'd2
    } arb_state_e;

    // Bits needed to hold an index in 0..n-1 (at least one bit).
    function automatic int idx_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// Requester-side bus of the register-bank arbiter: per-requester request,
// write strobe and data in; grant, status and bank contents out.
interface dff_bank_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    logic [N-1:0]       req;
    logic [N-1:0]       wr_en;
    logic [N*WIDTH-1:0] wdata;
    logic [N-1:0]       grant;
    logic               busy;
    logic               preempt;
    logic [WIDTH-1:0]   Q;

    modport master (
        output req, wr_en, wdata,
        input  grant, busy, preempt, Q
    );

    modport slave (
        input  req, wr_en, wdata,
        output grant, busy, preempt, Q
    );
endinterface

// File: rtl/dff_bank_arbiter_chk.sv
// Protocol checker for the arbiter outputs: grant is one-hot or zero and
// busy always reflects whether a grant is active.
module dff_bank_arbiter_chk #(
    parameter int N = 4
) (
    input logic         Clk,
    input logic         Reset_n,
    input logic [N-1:0] i_grant,
    input logic         i_busy
);

    a_grant_onehot0: assert property (
        @(posedge Clk) disable iff (!Reset_n) $onehot0(i_grant)
    );

    a_busy_matches_grant: assert property (
        @(posedge Clk) disable iff (!Reset_n) (i_busy == (|i_grant))
    );

endmodule

// File: rtl/dff_bank_r.sv
// Shared storage: WIDTH-bit register with asynchronous clear and an
// enable-gated load of D on the rising clock edge.
module dff_bank_r #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Bank storage: clear on reset, load D when enabled, otherwise hold.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter giving N requesters exclusive write ownership of one
// shared WIDTH-bit register bank, with a bounded hold time under contention.
module dff_bank_arbiter
    import dff_bank_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 8
) (
    input logic               Clk,
    input logic               Reset_n,
    dff_bank_arbiter_if.slave bus
);

    localparam int IW = idx_width(N);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [N-1:0]  ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};

    arb_state_e       r_state;
    logic [N-1:0]     r_grant;
    logic             r_busy;
    logic             r_preempt;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_owner;
    logic [HW-1:0]    r_hold;

    logic             w_pick_valid;
    logic [IW-1:0]    w_pick_idx;
    logic             w_owner_req;
    logic             w_others;
    logic             w_wr_load;
    logic [WIDTH-1:0] w_wr_data;
    logic [IW:0]      w_cand;

    // Round-robin search: first requester at or above the pointer, wrapping.
    // Scanning offsets high-to-low lets the smallest offset win last.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_idx   = '0;
        w_cand       = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_cand = {1'b0, r_ptr} + (IW+1)'(i);
            if (w_cand >= (IW+1)'(N)) begin
                w_cand = w_cand - (IW+1)'(N);
            end else begin
                w_cand = w_cand;
            end
            if (bus.req[w_cand[IW-1:0]]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = w_cand[IW-1:0];
            end else begin
                w_pick_valid = w_pick_valid;
            end
        end
    end

    // Owner status and write path; the owner's own req gates its write strobe.
    always_comb begin
        w_owner_req = |(bus.req & r_grant);
        w_others    = |(bus.req & ~r_grant);
        w_wr_load   = (r_state == S_OWNED) && (|(bus.req & bus.wr_en & r_grant));
        w_wr_data   = '0;
        for (int i = 0; i < N; i++) begin
            if (r_owner == IW'(i)) begin
                w_wr_data = bus.wdata[i*WIDTH +: WIDTH];
            end else begin
                w_wr_data = w_wr_data;
            end
        end
    end

    // Arbitration FSM: grant, hold-time enforcement, release and pointer advance.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_preempt <= 1'b0;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_hold    <= '0;
        end else begin
            r_preempt <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= ONE_HOT0 << w_pick_idx;
                        r_busy  <= 1'b1;
                        r_owner <= w_pick_idx;
                        r_hold  <= '0;
                        r_state <= S_OWNED;
                    end else begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                S_OWNED: begin
                    if (!w_owner_req) begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_hold  <= '0;
                        r_state <= S_RELEASE;
                    end else if (w_others) begin
                        if (r_hold == HOLD_LAST) begin
                            r_grant   <= '0;
                            r_busy    <= 1'b0;
                            r_preempt <= 1'b1;
                            r_hold    <= '0;
                            r_state   <= S_RELEASE;
                        end else begin
                            r_hold <= r_hold + HW'(1);
                        end
                    end else begin
                        r_hold <= '0;
                    end
                end
                S_RELEASE: begin
                    // Move past the last owner so it cannot win back-to-back.
                    if (r_owner == IW'(N - 1)) begin
                        r_ptr <= '0;
                    end else begin
                        r_ptr <= r_owner + IW'(1);
                    end
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_hold  <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    dff_bank_r #(.WIDTH(WIDTH)) u_bank (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .i_en    (w_wr_load),
        .i_d     (w_wr_data),
        .o_q     (bus.Q)
    );

    dff_bank_arbiter_chk #(.N(N)) u_chk (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .i_grant (r_grant),
        .i_busy  (r_busy)
    );

    assign bus.grant   = r_grant;
    assign bus.busy    = r_busy;
    assign bus.preempt = r_preempt;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench for dff_bank_arbiter: a cycle table for single-owner
// traffic, then hand sequences for reset, round-robin rotation and timeout.
module tb_dff_bank_arbiter;

    localparam int N        = 4;
    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 8;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;

    always #5 Clk = ~Clk;

    dff_bank_arbiter_if #(.N(N), .WIDTH(WIDTH)) bus ();

    dff_bank_arbiter #(.N(N), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  wr;
        logic [31:0] wdata;
        logic [3:0]  g;
        logic [7:0]  q;
        logic        pre;
    } vec_t;

    vec_t       vecs [14];
    logic [3:0] exp_q [$];
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [3:0] g;
        logic [3:0] prev;
        int         cnt;
        int         bad;
        bit         seen;

        // {req, wr_en, wdata, grant, Q, preempt} observed after one edge
        vecs[0]  = '{4'b0001, 4'b0000, 32'h0000_0000, 4'b0001, 8'h00, 1'b0};
        vecs[1]  = '{4'b0001, 4'b0001, 32'h0000_003C, 4'b0001, 8'h3C, 1'b0};
        vecs[2]  = '{4'b0001, 4'b0000, 32'h0000_0000, 4'b0001, 8'h3C, 1'b0};
        vecs[3]  = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 8'h3C, 1'b0};
        vecs[4]  = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 8'h3C, 1'b0};
        vecs[5]  = '{4'b0010, 4'b0000, 32'h0000_0000, 4'b0010, 8'h3C, 1'b0};
        vecs[6]  = '{4'b0010, 4'b0101, 32'h0033_2211, 4'b0010, 8'h3C, 1'b0};
        vecs[7]  = '{4'b0010, 4'b0010, 32'h0000_5A00, 4'b0010, 8'h5A, 1'b0};
        vecs[8]  = '{4'b0000, 4'b0010, 32'h0000_7700, 4'b0000, 8'h5A, 1'b0};
        vecs[9]  = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 8'h5A, 1'b0};
        vecs[10] = '{4'b0011, 4'b0000, 32'h0000_0000, 4'b0001, 8'h5A, 1'b0};
        vecs[11] = '{4'b0011, 4'b0000, 32'h0000_0000, 4'b0001, 8'h5A, 1'b0};
        vecs[12] = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 8'h5A, 1'b0};
        vecs[13] = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 8'h5A, 1'b0};

        bus.req   = 4'b0000;
        bus.wr_en = 4'b0000;
        bus.wdata = 32'h0000_0000;

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_preempt", 32'(bus.preempt), 32'h0);
        check("rst_q", 32'(bus.Q), 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Table: single owners, non-owner strobes, drop-with-write, pointer wrap
        for (int i = 0; i < 14; i++) begin
            bus.req   = vecs[i].req;
            bus.wr_en = vecs[i].wr;
            bus.wdata = vecs[i].wdata;
            step();
            check($sformatf("v%0d_grant", i), 32'(bus.grant), 32'(vecs[i].g));
            check($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(|vecs[i].g));
            check($sformatf("v%0d_preempt", i), 32'(bus.preempt), 32'(vecs[i].pre));
            check($sformatf("v%0d_q", i), 32'(bus.Q), 32'(vecs[i].q));
        end

        // Asynchronous reset while requester 1 owns the bank holding A5
        bus.req = 4'b0010;
        step();
        check("a_grant", 32'(bus.grant), 32'h2);
        bus.wr_en = 4'b0010;
        bus.wdata = 32'h0000_A500;
        step();
        bus.wr_en = 4'b0000;
        check("a_q_loaded", 32'(bus.Q), 32'hA5);
        #2;
        Reset_n = 1'b0;
        #1;
        check("a_rst_grant", 32'(bus.grant), 32'h0);
        check("a_rst_busy", 32'(bus.busy), 32'h0);
        check("a_rst_q", 32'(bus.Q), 32'h0);
        bus.req = 4'b0000;
        @(negedge Clk);
        Reset_n = 1'b1;
        step();

        // Rotation: all requesting, each owner leaves after two cycles
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        bus.req = 4'b1111;
        prev = 4'b0000;
        cnt  = 0;
        for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
            step();
            g = bus.grant;
            if (g != 4'b0000) begin
                if (g != prev) begin
                    check("b_dead_cycle", 32'(prev), 32'h0);
                    check("b_grant_order", 32'(g), 32'(exp_q.pop_front()));
                    cnt = 1;
                end else begin
                    cnt++;
                end
                if (cnt == 2) begin
                    bus.req = bus.req & ~g;
                end
            end else begin
                bus.req = 4'b1111;
            end
            prev = g;
        end
        check("b_sb_drained", 32'(exp_q.size()), 32'h0);
        bus.req = 4'b0000;
        repeat (3) step();

        // Timeout: requester 2 holds while requester 0 waits
        bus.req = 4'b0100;
        step();
        check("c_first_grant", 32'(bus.grant), 32'h4);
        bus.req = 4'b0101;
        bad = 0;
        for (int c = 0; c < MAX_HOLD - 1; c++) begin
            step();
            if (bus.grant != 4'b0100 || bus.preempt != 1'b0) begin
                bad++;
            end
        end
        check("c_hold_window_errors", 32'(bad), 32'h0);
        bus.wr_en = 4'b0100;
        bus.wdata = 32'h00C3_0000;
        step();
        bus.wr_en = 4'b0000;
        check("c_timeout_grant", 32'(bus.grant), 32'h0);
        check("c_preempt_pulse", 32'(bus.preempt), 32'h1);
        check("c_last_write", 32'(bus.Q), 32'hC3);
        step();
        check("c_preempt_single", 32'(bus.preempt), 32'h0);
        exp_q.push_back(4'b0001);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            step();
            if (bus.grant != 4'b0000) begin
                seen = 1'b1;
                check("c_next_grant", 32'(bus.grant), 32'(exp_q.pop_front()));
            end
        end
        check("c_next_grant_seen", 32'(seen), 32'h1);
        bus.req = 4'b0000;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
